// File: rtl/stereo_audio_serializer.sv
// -----------------------------------------------------------------------------
// stereo_audio_serializer
//
// Converts parallel stereo sample pairs into a serial sample stream. Each
// accepted pair is emitted as two output beats: the left word first
// (o_is_left=1), then the right word (o_is_left=0). Samples pass through
// bit-exact.
//
// Buffering is two deep: the output stage holds the pair currently being
// emitted, and a pending register can hold one more pair. With o_ready held
// high this sustains one sample per clock (one pair every two clocks).
//
// Ports:
//   clk        system clock, all logic on rising edge
//   reset      synchronous, active-high reset (wins over everything)
//   i_valid    input pair valid
//   i_ready    serializer can accept a pair (registers and reset only)
//   i_left     left sample of the offered pair
//   i_right    right sample of the offered pair
//   o_valid    serial sample valid (registered)
//   o_ready    downstream accepts sample
//   o_is_left  1 = o_audio carries the left sample, 0 = right (registered)
//   o_audio    serial sample (registered)
// -----------------------------------------------------------------------------
module stereo_audio_serializer #(
  parameter int AUDIO_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_valid,
  output logic                   i_ready,
  input  logic [AUDIO_WIDTH-1:0] i_left,
  input  logic [AUDIO_WIDTH-1:0] i_right,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic                   o_is_left,
  output logic [AUDIO_WIDTH-1:0] o_audio
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } state_t;

  state_t                 state_r;
  logic [AUDIO_WIDTH-1:0] out_left_r;
  logic [AUDIO_WIDTH-1:0] out_right_r;
  logic [AUDIO_WIDTH-1:0] pend_left_r;
  logic [AUDIO_WIDTH-1:0] pend_right_r;
  logic                   pend_valid_r;
  logic                   o_valid_r;
  logic                   o_is_left_r;
  logic [AUDIO_WIDTH-1:0] o_audio_r;

  logic                   in_fire_s;
  logic                   out_fire_s;
  logic                   free_s;

  // A new pair can only be taken while the pending slot is empty; this keeps
  // i_ready free of any combinational path from o_ready.
  assign i_ready    = !pend_valid_r && !reset;
  assign in_fire_s  = i_valid && i_ready;
  assign out_fire_s = o_valid_r && o_ready;

  // The output stage can take a new pair when idle or when the right word is
  // leaving this cycle. Any encoding other than LEFT/RIGHT is treated as idle
  // so a corrupted state register recovers on the next edge.
  assign free_s = (state_r == ST_RIGHT) ? out_fire_s : (state_r != ST_LEFT);

  assign o_valid   = o_valid_r;
  assign o_is_left = o_is_left_r;
  assign o_audio   = o_audio_r;

  // Output state machine, pending-pair register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_EMPTY;
      out_left_r   <= {AUDIO_WIDTH{1'b0}};
      out_right_r  <= {AUDIO_WIDTH{1'b0}};
      pend_left_r  <= {AUDIO_WIDTH{1'b0}};
      pend_right_r <= {AUDIO_WIDTH{1'b0}};
      pend_valid_r <= 1'b0;
      o_valid_r    <= 1'b0;
      o_is_left_r  <= 1'b0;
      o_audio_r    <= {AUDIO_WIDTH{1'b0}};
    end else if (free_s) begin
      if (pend_valid_r) begin
        // The pending pair is older than anything on the input, so it goes first.
        state_r      <= ST_LEFT;
        out_left_r   <= pend_left_r;
        out_right_r  <= pend_right_r;
        pend_valid_r <= 1'b0;
        o_valid_r    <= 1'b1;
        o_is_left_r  <= 1'b1;
        o_audio_r    <= pend_left_r;
      end else if (in_fire_s) begin
        // Bypass: load straight into the output stage.
        state_r      <= ST_LEFT;
        out_left_r   <= i_left;
        out_right_r  <= i_right;
        o_valid_r    <= 1'b1;
        o_is_left_r  <= 1'b1;
        o_audio_r    <= i_left;
      end else begin
        state_r      <= ST_EMPTY;
        o_valid_r    <= 1'b0;
        o_is_left_r  <= 1'b0;
        o_audio_r    <= {AUDIO_WIDTH{1'b0}};
      end
    end else begin
      if ((state_r == ST_LEFT) && out_fire_s) begin
        state_r     <= ST_RIGHT;
        o_is_left_r <= 1'b0;
        o_audio_r   <= out_right_r;
      end else begin
        // Stalled: all outputs hold so the producer rule is kept.
        state_r     <= state_r;
      end
      // in_fire implies pend_valid_r == 0, so nothing is ever overwritten.
      if (in_fire_s) begin
        pend_left_r  <= i_left;
        pend_right_r <= i_right;
        pend_valid_r <= 1'b1;
      end else begin
        pend_valid_r <= pend_valid_r;
      end
    end
  end

endmodule

// File: tb/tb_stereo_audio_serializer.sv
// -----------------------------------------------------------------------------
// Testbench for stereo_audio_serializer. Stimulus pushes the expected serial
// samples into a scoreboard queue; an independent monitor pops and compares
// on every output transfer and checks that stalled outputs stay stable.
// -----------------------------------------------------------------------------
module tb_stereo_audio_serializer;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         i_valid;
  logic         i_ready;
  logic [W-1:0] i_left;
  logic [W-1:0] i_right;
  logic         o_valid;
  logic         o_ready;
  logic         o_is_left;
  logic [W-1:0] o_audio;

  stereo_audio_serializer #(.AUDIO_WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_valid   (i_valid),
    .i_ready   (i_ready),
    .i_left    (i_left),
    .i_right   (i_right),
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .o_is_left (o_is_left),
    .o_audio   (o_audio)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int in_count = 0;
  int out_count = 0;
  int last_in_cyc = 0;
  int last_out_cyc = 0;
  int last_stalls = 0;
  logic [W:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: compares every output transfer, checks stall stability.
  initial begin : monitor
    logic       stall_prev;
    logic [W:0] prev;
    logic [W:0] e;
    stall_prev = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          chk("hold_valid", {63'd0, o_valid}, 64'd1);
          chk("hold_data", {31'd0, o_is_left, o_audio}, {31'd0, prev});
        end
        if (o_valid && o_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_out: got %0h expected nothing", {o_is_left, o_audio});
          end else begin
            e = exp_q.pop_front();
            chk("out_sample", {31'd0, o_is_left, o_audio}, {31'd0, e});
          end
          out_count++;
          last_out_cyc = cyc + 1;
        end
        stall_prev = o_valid && !o_ready;
        prev = {o_is_left, o_audio};
      end
    end
  end

  // Offer one pair, wait (bounded) for acceptance, push the expected samples.
  task automatic send(input logic [W-1:0] l, input logic [W-1:0] r);
    int stalls;
    stalls = 0;
    i_valid = 1'b1;
    i_left  = l;
    i_right = r;
    while (!i_ready && stalls < 100) begin
      @(posedge clk); #1;
      stalls++;
    end
    if (!i_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got i_ready=0 expected 1");
    end else begin
      exp_q.push_back({1'b1, l});
      exp_q.push_back({1'b0, r});
      @(posedge clk); #1;
      in_count++;
      last_in_cyc = cyc;
    end
    last_stalls = stalls;
    i_valid = 1'b0;
  endtask

  // Wait (bounded) until all expected samples have left and the output idles.
  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || o_valid) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0 || o_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  logic [W-1:0] stream_l [4] = '{32'h2eef2eef, 32'h12345678, 32'h99911223, 32'h55555555};
  logic [W-1:0] stream_r [4] = '{32'h33333333, 32'h1fed1fed, 32'habcdef01, 32'h44444444};
  logic [W-1:0] alt_l    [4] = '{32'h00000001, 32'hdeadbeef, 32'h80000000, 32'hffffffff};
  logic [W-1:0] alt_r    [4] = '{32'h00000002, 32'hcafef00d, 32'h7fffffff, 32'h00000000};

  initial begin
    int first_in;
    int stall_sum;
    int in0;
    int out0;
    logic done;
    reset = 1'b1;
    i_valid = 1'b0;
    i_left = '0;
    i_right = '0;
    o_ready = 1'b1;

    // Reset then idle
    repeat (2) begin @(posedge clk); #1; end
    chk("rst_o_valid", {63'd0, o_valid}, 64'd0);
    chk("rst_o_is_left", {63'd0, o_is_left}, 64'd0);
    chk("rst_o_audio", {32'd0, o_audio}, 64'd0);
    chk("rst_i_ready", {63'd0, i_ready}, 64'd0);
    reset = 1'b0;
    #1;
    chk("idle_i_ready", {63'd0, i_ready}, 64'd1);
    @(posedge clk); #1;
    chk("idle_o_valid", {63'd0, o_valid}, 64'd0);

    // Single pair: left appears the cycle after acceptance
    send(32'h00010000, 32'h1fed1fed);
    chk("lat_o_valid", {63'd0, o_valid}, 64'd1);
    chk("lat_left", {31'd0, o_is_left, o_audio}, {31'd0, 1'b1, 32'h00010000});
    @(posedge clk); #1;
    chk("lat_right", {31'd0, o_is_left, o_audio}, {31'd0, 1'b0, 32'h1fed1fed});
    @(posedge clk); #1;
    chk("single_done", {63'd0, o_valid}, 64'd0);

    // Streaming, o_ready=1: gap-free L,R x4 and i_ready toggling
    stall_sum = 0;
    first_in = 0;
    for (int i = 0; i < 4; i++) begin
      send(stream_l[i], stream_r[i]);
      if (i == 0) first_in = last_in_cyc;
      stall_sum += last_stalls;
    end
    drain();
    chk("stream_span", 64'(last_out_cyc - first_in), 64'd8);
    chk("stream_stalls", 64'(stall_sum), 64'd2);

    // Backpressure: hold the left word, pending fills, i_ready drops
    o_ready = 1'b0;
    send(32'h2eef2eef, 32'h33333333);
    send(32'h12345678, 32'h1fed1fed);
    for (int i = 0; i < 4; i++) begin
      chk("bp_i_ready", {63'd0, i_ready}, 64'd0);
      chk("bp_hold", {31'd0, o_valid, o_is_left, o_audio}, {31'd0, 2'b11, 32'h2eef2eef});
      @(posedge clk); #1;
    end
    o_ready = 1'b1;
    drain();

    // Alternating o_ready with continuous input
    in0 = in_count;
    out0 = out_count;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(alt_l[i], alt_r[i]);
        drain();
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          o_ready = ~o_ready;
        end
      end
    join
    o_ready = 1'b1;
    drain();
    chk("alt_counts", 64'(out_count - out0), 64'(2 * (in_count - in0)));

    // Reset while RIGHT with a pending pair: everything discarded
    o_ready = 1'b0;
    send(32'hfeedface, 32'h0badf00d);
    send(32'h11112222, 32'h33334444);
    o_ready = 1'b1;
    @(posedge clk); #1;
    chk("pre_rst_right", {31'd0, o_valid, o_is_left, o_audio}, {31'd0, 2'b10, 32'h0badf00d});
    o_ready = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_o_valid", {63'd0, o_valid}, 64'd0);
    chk("midrst_i_ready", {63'd0, i_ready}, 64'd0);
    reset = 1'b0;
    o_ready = 1'b1;
    @(posedge clk); #1;
    chk("postrst_idle", {63'd0, o_valid}, 64'd0);
    send(32'h99911223, 32'h13572468);
    chk("postrst_first", {31'd0, o_valid, o_is_left, o_audio}, {31'd0, 2'b11, 32'h99911223});
    drain();
    repeat (3) begin @(posedge clk); #1; end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stereo_audio_serializer.md
Name: stereo_audio_serializer

Overview:
- Converts parallel stereo sample pairs (left/right word per handshake) into a serial sample stream tagged with o_is_left. Within each pair, the left word is emitted first, then the right word.
- Inverse of the stereo parallelizer. Sits between stereo processing blocks (e.g. echo effect) and mono-lane sinks such as the I2S/serial transmitter.
- Two-deep buffering (output stage + pending pair) sustains one sample per clock when o_ready is held high.

Parameters:
AUDIO_WIDTH, 32, bit width of each channel sample

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
i_valid  input  1  input pair valid
i_ready  output  1  serializer can accept a pair
i_left  input  AUDIO_WIDTH  left sample of pair
i_right  input  AUDIO_WIDTH  right sample of pair
o_valid  output  1  serial sample valid
o_ready  input  1  downstream accepts sample
o_is_left  output  1  1 = o_audio is left sample, 0 = right
o_audio  output  AUDIO_WIDTH  serial sample

Behaviour:
- Reset is synchronous and active-high on clk, and wins over all other events.
  - Clears: output state to EMPTY, pend_valid to 0, sample registers to 0.
  - Resulting outputs: o_valid=0, o_is_left=0, o_audio=0, i_ready=0 while reset is high.
  - Reset mid-pair discards both the in-flight and pending pairs; no partial pair is emitted afterwards.
- Handshakes follow the usual valid/ready rule: a transfer occurs on an edge where valid && ready.
  - Input fire: in_fire = i_valid && i_ready. Output fire: out_fire = o_valid && o_ready.
  - Producer rule: o_valid, o_is_left and o_audio must stay stable while o_valid && !o_ready.
- i_ready = !pend_valid && !reset, driven from registers only, with no combinational path from o_ready.
- Output state machine:
  - States: EMPTY (o_valid=0), LEFT (o_valid=1, o_is_left=1, o_audio=out_left), RIGHT (o_valid=1, o_is_left=0, o_audio=out_right).
  - LEFT with out_fire -> RIGHT.
  - LEFT without out_fire, or RIGHT without out_fire -> hold.
- "Free" condition: the output stage is free at an edge when state==EMPTY, or state==RIGHT && out_fire. When free:
  - If pend_valid: load out_left/out_right from the pending pair, clear pend_valid, go to LEFT.
  - Else if in_fire: load directly from i_left/i_right, go to LEFT (bypass).
  - Else go to EMPTY.
- When not free and in_fire: store the pair in the pending register and set pend_valid. in_fire cannot coincide with pend_valid=1, so no overwrite case exists.
- Latency: with the block idle, o_valid rises in the cycle after in_fire, with the left sample.
- Throughput: with o_ready held high, consecutive pairs produce a gap-free L,R,L,R stream. i_ready toggles, accepting one pair per 2 cycles.
- Ordering: samples always leave in input order, left then right per pair. Never two lefts or two rights in a row.
- Arithmetic: none. Samples pass through bit-exact; no truncation or sign handling.

Test Plan:
- Reset then idle: hold reset 2 cycles, i_valid=0 -> o_valid=0, o_is_left=0, o_audio=0, i_ready=0 during reset and 1 after.
- Single pair, o_ready=1: pair (L=00010000, R=1fed1fed) -> next cycle o_valid=1, o_is_left=1, o_audio=00010000; following cycle o_is_left=0, o_audio=1fed1fed; then o_valid=0.
- Streaming, o_ready=1: pairs (2eef2eef,33333333), (12345678,1fed1fed), (99911223,abcdef01), (55555555,44444444) offered back-to-back -> 8 consecutive o_valid cycles, no bubble, exact order L,R,L,R…; i_ready low on every other cycle.
- Backpressure: o_ready=0 for 5 cycles after first pair -> o_audio holds 2eef2eef with o_is_left=1 and stays stable. The second pair is accepted into pending, then i_ready=0 until o_ready returns. On release, the output order is preserved exactly.
- Alternating o_ready (1,0,1,0…) with continuous input -> every output fire matches the expected sequence; no sample is lost or duplicated. Sample counts (outputs = 2 × inputs) must match at the end.
- Reset mid-pair: assert reset while state==RIGHT with pend_valid=1 -> next cycle o_valid=0. After release, the first output is the left sample of a newly supplied pair (99911223); no stale data appears.
